// File: rtl/risp_pkg.sv
// Shared definitions for the RISP synapse array.
//   cfg_state_t : states of the configuration FSM (idle / apply)
//   delay_w()   : bit width needed to hold a programmed delay 0..max_delay
//   addr_w()    : bit width of a channel address (at least one bit)
package risp_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    function automatic int delay_w(input int max_delay);
        return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
    endfunction

    function automatic int addr_w(input int num_syn);
        return (num_syn < 2) ? 1 : $clog2(num_syn);
    endfunction

endpackage

// File: rtl/risp_delay_line.sv
// One synapse channel's spike delay line with a programmable tap.
//   clk   : rising-edge clock
//   arst  : asynchronous active-high reset, empties the line
//   clr   : synchronous clear of the line, wins over en
//   en    : advance the line by one timestep
//   inp   : spike input (stage 0 of the line)
//   delay : programmed delay; the tap sits at delay - FIRE_LIKE_RAVENS
//   tap   : spike value at the selected stage
module risp_delay_line
    import risp_pkg::*;
#(
    parameter int MAX_DELAY        = 15,
    parameter int FIRE_LIKE_RAVENS = 0
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          inp,
    input  logic [delay_w(MAX_DELAY)-1:0] delay,
    output logic                          tap
);

    localparam int DW = delay_w(MAX_DELAY);

    logic [MAX_DELAY:1] line;
    logic [MAX_DELAY:0] stages;
    logic [DW-1:0]      d_eff;

    // Stage 0 is the live input, so an effective delay of zero is a
    // purely combinational path from inp to tap.
    assign stages = {line, inp};
    assign d_eff  = delay - DW'(FIRE_LIKE_RAVENS);

    always_comb begin
        tap = 1'b0;
        if (32'(d_eff) <= MAX_DELAY) begin
            tap = stages[d_eff];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (en) begin
            line <= stages[MAX_DELAY-1:0];
        end
    end

endmodule

// File: rtl/risp_synapse_array.sv
// Array of NUM_SYN independent delayed synapses with a configuration port.
//   clk        : rising-edge clock
//   arst       : asynchronous active-high reset
//   clr        : synchronous clear of every delay line
//   en         : advance all delay lines one timestep
//   inp        : per-channel spike input
//   out        : per-channel signed charge (weight when the tap fires, else 0)
//   cfg_valid  : configuration request
//   cfg_ready  : high while the config port can accept a request
//   cfg_addr   : target channel
//   cfg_weight : new signed weight
//   cfg_delay  : new programmed delay
//   cfg_err    : one-cycle pulse after a rejected request
module risp_synapse_array
    import risp_pkg::*;
#(
    parameter int NUM_SYN          = 4,
    parameter int MAX_DELAY        = 15,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int CHARGE_WIDTH     = 16,
    parameter int FIRE_LIKE_RAVENS = 0,
    parameter int INIT_WEIGHT      = 1,
    parameter int INIT_DELAY       = 1
) (
    input  logic                                        clk,
    input  logic                                        arst,
    input  logic                                        clr,
    input  logic                                        en,
    input  logic [NUM_SYN-1:0]                          inp,
    output logic signed [NUM_SYN-1:0][CHARGE_WIDTH-1:0] out,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [addr_w(NUM_SYN)-1:0]                  cfg_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]              cfg_weight,
    input  logic [delay_w(MAX_DELAY)-1:0]               cfg_delay,
    output logic                                        cfg_err
);

    localparam int AW = addr_w(NUM_SYN);
    localparam int DW = delay_w(MAX_DELAY);

    cfg_state_t                     state;
    logic [AW-1:0]                  pend_addr;
    logic signed [WEIGHT_WIDTH-1:0] pend_weight;
    logic [DW-1:0]                  pend_delay;
    logic signed [WEIGHT_WIDTH-1:0] weight [NUM_SYN];
    logic [DW-1:0]                  delay  [NUM_SYN];
    logic [NUM_SYN-1:0]             tap;
    logic [NUM_SYN-1:0]             line_clr;
    logic                           cfg_legal;

    assign cfg_ready = (state == CFG_IDLE);

    // A programmed delay below FIRE_LIKE_RAVENS would give a negative tap.
    assign cfg_legal = (32'(cfg_addr) < NUM_SYN)
                    && (32'(cfg_delay) <= MAX_DELAY)
                    && !((FIRE_LIKE_RAVENS != 0) && (cfg_delay == '0));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= CFG_IDLE;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_legal) begin
                            state <= CFG_APPLY;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                CFG_APPLY: state <= CFG_IDLE;
                default:   state <= CFG_IDLE;
            endcase
        end
    end

    // Pending request is only consumed in APPLY, which reset leaves, so
    // these holding registers need no reset.
    always_ff @(posedge clk) begin
        if (cfg_ready && cfg_valid && cfg_legal) begin
            pend_addr   <= cfg_addr;
            pend_weight <= cfg_weight;
            pend_delay  <= cfg_delay;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int c = 0; c < NUM_SYN; c++) begin
                weight[c] <= WEIGHT_WIDTH'(INIT_WEIGHT);
                delay[c]  <= DW'(INIT_DELAY);
            end
        end else if (state == CFG_APPLY) begin
            for (int c = 0; c < NUM_SYN; c++) begin
                if (pend_addr == AW'(c)) begin
                    weight[c] <= pend_weight;
                    delay[c]  <= pend_delay;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_SYN; c++) begin : g_syn
        // Reprogramming a channel discards whatever was in flight on it,
        // so spikes never emerge with a mix of old and new timing.
        assign line_clr[c] = clr || ((state == CFG_APPLY) && (pend_addr == AW'(c)));

        risp_delay_line #(
            .MAX_DELAY        (MAX_DELAY),
            .FIRE_LIKE_RAVENS (FIRE_LIKE_RAVENS)
        ) u_line (
            .clk   (clk),
            .arst  (arst),
            .clr   (line_clr[c]),
            .en    (en),
            .inp   (inp[c]),
            .delay (delay[c]),
            .tap   (tap[c])
        );

        assign out[c] = tap[c] ? CHARGE_WIDTH'(weight[c]) : '0;
    end

endmodule
